// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel fixed-select / round-robin arbiter feeding a one-beat output register.
module rr_arb_mux #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  localparam int SW  = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [N_CH-1:0]      in_valid,
  input  logic [N_CH*DW-1:0]   in_data,
  output logic [N_CH-1:0]      in_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_ch,
  input  logic                 out_ready
);

  logic [N_CH-1:0] grant;
  logic            found;
  logic [DW-1:0]   sel_data;
  logic [SW-1:0]   sel_ch;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   rr_next;
  logic            load;
  logic            xfer;

  // Round-robin: offset k from rr_ptr lands on channel i when rr_ptr == (i - k) mod N_CH.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (mode) begin
      for (int k = 0; k < N_CH; k++) begin
        for (int i = 0; i < N_CH; i++) begin
          if (!found && in_valid[i] && (rr_ptr == SW'((i - k + N_CH) % N_CH))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == SW'(i)) begin
          grant[i] = in_valid[i];
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data = sel_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
      sel_ch   = sel_ch | (SW'(i) & {SW{grant[i]}});
    end
  end

  assign load     = !out_valid || out_ready;
  assign xfer     = load && (|grant);
  assign in_ready = (load && rst_n) ? grant : '0;
  assign rr_next  = (sel_ch == SW'(N_CH - 1)) ? '0 : sel_ch + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        out_valid <= |grant;
        if (|grant) begin
          out_data <= sel_data;
          out_ch   <= sel_ch;
        end
      end
      if (xfer && mode) begin
        rr_ptr <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - vector table, corner sequences and randomized model check for rr_arb_mux.
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.N_CH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  rr_arb_mux #(.N_CH(3), .DW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
    .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
    .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t tab[20];

  int m_valid, m_data, m_ch, m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input bit m, input int s, input logic [3:0] v, input int p);
    if (!m) return (s < 4 && v[s]) ? s : -1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    tab[0]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tab[1]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tab[2]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tab[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tab[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tab[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tab[6]  = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tab[7]  = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tab[8]  = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
    tab[9]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tab[10] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tab[11] = '{1'b1, 2'd0, 4'h1, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tab[12] = '{1'b1, 2'd0, 4'h9, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tab[13] = '{1'b1, 2'd0, 4'h9, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tab[14] = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tab[15] = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tab[16] = '{1'b0, 2'd2, 4'hB, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2};
    tab[17] = '{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};
    tab[18] = '{1'b0, 2'd2, 4'hB, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2};
    tab[19] = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};

    rst_n = 1'b0;
    mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'hccbbaa; out_ready3 = 1'b1;

    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_ch", out_ch, 0);
    check("reset in_ready", in_ready, 0);
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mode = tab[i].mode; sel = tab[i].sel; in_valid = tab[i].valid; out_ready = tab[i].ready;
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, tab[i].exp_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), out_valid, tab[i].exp_ov);
      check($sformatf("vec%0d out_data", i), out_data, tab[i].exp_od);
      check($sformatf("vec%0d out_ch", i), out_ch, tab[i].exp_ch);
    end

    // Asynchronous reset between edges while a beat is held; rr_ptr was 3 before it.
    @(negedge clk);
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 0);
    check("async out_data", out_data, 0);
    check("async out_ch", out_ch, 0);
    check("async in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("in reset in_ready", in_ready, 0);
    check("in reset out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("post reset in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    check("post reset out_ch", out_ch, 0);
    check("post reset out_data", out_data, 8'h11);
    check("post reset out_valid", out_valid, 1);

    // Three-channel instance: out-of-range select, then fixed, then wrapping round robin.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("n3 oor in_ready", in_ready3, 0);
      @(posedge clk); #1;
      check("n3 oor out_valid", out_valid3, 0);
    end
    @(negedge clk);
    sel3 = 2'd2;
    #1;
    check("n3 sel2 in_ready", in_ready3, 3'b100);
    @(posedge clk); #1;
    check("n3 sel2 out_data", out_data3, 8'hcc);
    check("n3 sel2 out_ch", out_ch3, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mode3 = 1'b1;
      #1;
      check($sformatf("n3 rr%0d in_ready", k), in_ready3, 3'b001 << (k % 3));
      @(posedge clk); #1;
      check($sformatf("n3 rr%0d out_ch", k), out_ch3, k % 3);
    end

    // Randomized run against the reference model.
    @(negedge clk);
    in_valid = 4'h0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    for (int n = 0; n < 400; n++) begin
      int g;
      bit ld;
      logic [3:0] er;
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      g = pick(mode, int'(sel), in_valid, m_ptr);
      ld = (m_valid == 0) || out_ready;
      er = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("rand in_ready", in_ready, er);
      @(posedge clk); #1;
      if (ld) begin
        if (g >= 0) begin
          m_valid = 1;
          m_data = int'(in_data[g*8 +: 8]);
          m_ch = g;
          if (mode) m_ptr = (g + 1) % 4;
        end else begin
          m_valid = 0;
        end
      end
      check("rand out_valid", out_valid, m_valid);
      check("rand out_data", out_data, m_data);
      check("rand out_ch", out_ch, m_ch);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
